// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle TP-OC2 controller.
package ctrl_pkg;

  localparam logic [3:0] OP_JMP = 4'd11;
  localparam logic [3:0] OP_BR  = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MULW  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [1:0] FC_SEQ = 2'b00;
  localparam logic [1:0] FC_BR  = 2'b01;
  localparam logic [1:0] FC_JMP = 2'b10;

  localparam logic [1:0] UB_REG = 2'b00;
  localparam logic [1:0] UB_IMM = 2'b10;

  // One-hot opcode class
  typedef struct packed {
    logic rr;
    logic imm;
    logic jmp;
    logic br;
    logic mul;
    logic ill;
  } classe_t;

endpackage

// File: rtl/decod_classe.sv
// Opcode -> one-hot class decoder; shared with the pipelined controller.
module decod_classe
  import ctrl_pkg::*;
#(
  parameter logic [3:0] MUL_OPCODE = OP_MUL
) (
  input  logic [3:0] opcode,
  output classe_t    classe
);

  // MUL_OPCODE takes priority so the multiplier can be remapped
  always_comb begin
    classe = '0;
    if (opcode == MUL_OPCODE) begin
      classe.mul = 1'b1;
    end else begin
      case (opcode)
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5:         classe.rr  = 1'b1;
        4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:  classe.imm = 1'b1;
        OP_JMP:                               classe.jmp = 1'b1;
        OP_BR:                                classe.br  = 1'b1;
        default:                              classe.ill = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM: FETCH -> EXEC -> [MULW] -> WB, with a guarded
// start/done handshake to the external multiplier.
module controle_multiciclo
  import ctrl_pkg::*;
#(
  parameter logic [3:0] MUL_OPCODE  = OP_MUL,
  parameter int         MUL_TIMEOUT = 16,
  parameter int         CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       imem_ready,
  input  logic       mul_done,
  output logic       EscIR,
  output logic       EscCP,
  output logic       EscCondCP,
  output logic [1:0] FonteCP,
  output logic [3:0] ULA_OP,
  output logic       ULA_A,
  output logic [1:0] ULA_B,
  output logic       flagimm,
  output logic       EscReg,
  output logic       mul_start,
  output logic       busy,
  output logic       erro_mul,
  output logic       ilegal
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mul_to;   // current MUL ended by timeout: suppress WB write
  classe_t          cls;
  logic             tmo;

  decod_classe #(.MUL_OPCODE(MUL_OPCODE)) u_dec (
    .opcode (opcode),
    .classe (cls)
  );

  assign tmo = (cnt == CNT_W'(MUL_TIMEOUT - 1));

  // State sequencing, multiplier handshake and timeout bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      cnt       <= '0;
      mul_to    <= 1'b0;
      mul_start <= 1'b0;
      erro_mul  <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        FETCH: if (imem_ready) state <= EXEC;
        EXEC: begin
          if (cls.mul) begin
            state     <= MULW;
            mul_start <= 1'b1;
          end else begin
            state <= WB;
          end
        end
        MULW: begin
          // done wins over a simultaneous timeout
          if (mul_done) begin
            state <= WB;
            cnt   <= '0;
          end else if (tmo) begin
            state    <= WB;
            cnt      <= '0;
            mul_to   <= 1'b1;
            erro_mul <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          state  <= FETCH;
          mul_to <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state and opcode class; all held low in reset
  always_comb begin
    EscIR     = 1'b0;
    EscCP     = 1'b0;
    EscCondCP = 1'b0;
    FonteCP   = FC_SEQ;
    ULA_OP    = 4'd0;
    ULA_A     = 1'b0;
    ULA_B     = UB_REG;
    flagimm   = 1'b0;
    EscReg    = 1'b0;
    busy      = 1'b0;
    ilegal    = 1'b0;
    if (rst) begin
      case (state)
        FETCH: EscIR = imem_ready;
        EXEC: begin
          busy   = 1'b1;
          ULA_OP = opcode;
          ULA_A  = cls.rr | cls.imm | cls.mul;
          if (cls.imm) begin
            ULA_B   = UB_IMM;
            flagimm = 1'b1;
          end
          ilegal = cls.ill;
        end
        MULW: begin
          busy   = 1'b1;
          ULA_OP = opcode;
          ULA_A  = 1'b1;
          ULA_B  = UB_REG;
        end
        WB: begin
          busy      = 1'b1;
          ULA_OP    = opcode;
          EscCP     = 1'b1;
          EscCondCP = cls.br;
          FonteCP   = cls.jmp ? FC_JMP : (cls.br ? FC_BR : FC_SEQ);
          EscReg    = (cls.rr | cls.imm | cls.mul) & ~mul_to;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: per-instruction expected output traces built from the
// instruction-level behaviour, compared cycle by cycle against the controller.
module tb_controle_multiciclo;

  localparam int MUL_TIMEOUT = 16;

  logic       clk, rst;
  logic [3:0] opcode;
  logic       imem_ready, mul_done;
  logic       EscIR, EscCP, EscCondCP, ULA_A, flagimm, EscReg, mul_start, busy, erro_mul, ilegal;
  logic [1:0] FonteCP, ULA_B;
  logic [3:0] ULA_OP;

  controle_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .mul_done(mul_done),
    .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP), .FonteCP(FonteCP),
    .ULA_OP(ULA_OP), .ULA_A(ULA_A), .ULA_B(ULA_B), .flagimm(flagimm), .EscReg(EscReg),
    .mul_start(mul_start), .busy(busy), .erro_mul(erro_mul), .ilegal(ilegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       escir;
    logic       esccp;
    logic       esccond;
    logic [1:0] fcp;
    logic [3:0] op;
    logic       ua;
    logic [1:0] ub;
    logic       fimm;
    logic       escreg;
    logic       mstart;
    logic       busy;
    logic       erro;
    logic       ileg;
  } ov_t;

  ov_t exp_q[$];
  ov_t got_q[$];
  bit  erro_m;
  int  n_chk, n_fail;

  function automatic ov_t sample();
    ov_t s;
    s.escir = EscIR; s.esccp = EscCP; s.esccond = EscCondCP; s.fcp = FonteCP;
    s.op = ULA_OP; s.ua = ULA_A; s.ub = ULA_B; s.fimm = flagimm; s.escreg = EscReg;
    s.mstart = mul_start; s.busy = busy; s.erro = erro_mul; s.ileg = ilegal;
    return s;
  endfunction

  // Expected trace of one instruction: ready after rdly stalled fetch cycles,
  // multiplier done in MULW cycle done_at (0 or beyond timeout = never).
  task automatic model_instr(input logic [3:0] op, input int rdly, input int done_at);
    ov_t e;
    bit  rr, imm, jmp, br, mul, ill, tmo;
    int  nw, o;
    o   = op;
    rr  = o inside {0, 1, 3, 4, 5};
    imm = o inside {2, [6:10]};
    jmp = (o == 11);
    br  = (o == 12);
    mul = (o == 13);
    ill = (o >= 14);
    for (int c = 0; c <= rdly; c++) begin
      e = '0; e.erro = erro_m; e.escir = (c == rdly);
      exp_q.push_back(e);
    end
    e = '0; e.erro = erro_m; e.busy = 1'b1; e.op = op;
    e.ua = rr | imm | mul;
    if (imm) begin e.ub = 2'b10; e.fimm = 1'b1; end
    e.ileg = ill;
    exp_q.push_back(e);
    tmo = 1'b0;
    if (mul) begin
      tmo = !(done_at >= 1 && done_at <= MUL_TIMEOUT);
      nw  = tmo ? MUL_TIMEOUT : done_at;
      for (int i = 1; i <= nw; i++) begin
        e = '0; e.erro = erro_m; e.busy = 1'b1; e.op = op; e.ua = 1'b1; e.mstart = (i == 1);
        exp_q.push_back(e);
      end
    end
    if (tmo) erro_m = 1'b1;
    e = '0; e.erro = erro_m; e.busy = 1'b1; e.op = op; e.esccp = 1'b1;
    e.fcp = jmp ? 2'b10 : (br ? 2'b01 : 2'b00);
    e.esccond = br;
    e.escreg = (rr | imm | mul) & ~tmo;
    exp_q.push_back(e);
  endtask

  // Drives one instruction by cycle index and records outputs at negedge.
  // Starts and ends 1 time unit after a rising edge.
  task automatic run_instr(input logic [3:0] op, input int rdly, input int done_at, input bit fetch_done);
    int n0, ncyc;
    n0 = exp_q.size();
    model_instr(op, rdly, done_at);
    ncyc = exp_q.size() - n0;
    for (int c = 0; c < ncyc; c++) begin
      opcode     = op;
      imem_ready = (c == rdly);
      mul_done   = (done_at >= 1 && c == rdly + 1 + done_at) || (fetch_done && c == 0);
      @(negedge clk);
      got_q.push_back(sample());
      @(posedge clk); #1;
    end
    mul_done   = 1'b0;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    ov_t g;
    rst = 1'b0; imem_ready = 1'b1; mul_done = 1'b1; opcode = 4'($urandom_range(15, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = sample();
      n_chk++;
      if (g !== '0) begin
        n_fail++; $display("FAIL reset_outputs cyc %0d got %h required 0", i, g);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; mul_done = 1'b0; erro_m = 1'b0;
    exp_q.delete(); got_q.delete();
    run_instr(4'd0, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_release cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_add_stall();
    exp_q.delete(); got_q.delete();
    run_instr(4'd0, 4, 0, 1'b0);
    run_instr(4'd7, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL add_stall cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    exp_q.delete(); got_q.delete();
    run_instr(4'd12, 0, 0, 1'b0);
    run_instr(4'd11, 0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL branch_jump cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mul();
    exp_q.delete(); got_q.delete();
    run_instr(4'd13, 0, 6, 1'b0);   // done 5 cycles after mul_start
    run_instr(4'd1, 1, 0, 1'b1);    // done pulsed in FETCH must be ignored
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mul_handshake cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mul_timeout();
    exp_q.delete(); got_q.delete();
    run_instr(4'd13, 0, 0, 1'b0);
    run_instr(4'd0, 0, 0, 1'b0);
    run_instr(4'd13, 0, MUL_TIMEOUT, 1'b0);
    run_instr(4'd13, 0, MUL_TIMEOUT - 1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mul_timeout cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    exp_q.delete(); got_q.delete();
    run_instr(4'd14, 0, 0, 1'b0);
    run_instr(4'd15, 2, 1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL illegal cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    ov_t g;
    exp_q.delete(); got_q.delete();
    opcode = 4'd13; imem_ready = 1'b1;
    @(posedge clk); #1;                      // EXEC
    imem_ready = 1'b0;
    @(posedge clk); #1;                      // MULW 1
    @(posedge clk); #1;                      // MULW 2
    #2 rst = 1'b0;
    #1 g = sample();
    n_chk++;
    if (g !== '0) begin
      n_fail++; $display("FAIL reset_mid_async got %h required 0", g);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      mul_done = 1'b1; imem_ready = 1'b1;
      @(negedge clk);
      g = sample();
      n_chk++;
      if (g !== '0) begin
        n_fail++; $display("FAIL reset_mid_hold cyc %0d got %h required 0", i, g);
      end
    end
    @(posedge clk); #1;
    mul_done = 1'b0; imem_ready = 1'b0; rst = 1'b1; erro_m = 1'b0;
    run_instr(4'd3, 0, 0, 1'b0);
    run_instr(4'd13, 0, MUL_TIMEOUT, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_mid_recover cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    int rdly, dat;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 60; k++) begin
      op   = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) op = 4'd13;
      rdly = $urandom_range(3, 0);
      dat  = $urandom_range(MUL_TIMEOUT + 3, 0);
      run_instr(op, rdly, dat, 1'($urandom_range(1, 0)));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random cyc %0d got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; erro_m = 1'b0;
    rst = 1'b0; opcode = 4'd0; imem_ready = 1'b0; mul_done = 1'b0;
    test_reset();
    test_add_stall();
    test_branch_jump();
    test_mul();
    test_mul_timeout();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
